wb_pipe_stage: RTL and testbench

WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

---
 rtl/wb_pipe_stage.sv | 146 ++++++++++++++
 tb/tb_wb_pipe_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_stage.sv
// -----------------------------------------------------------------------------
// wb_pipe_stage
//
// Write-back pipeline register for an in-order core. The memory-stage bundle
// travels through DEPTH cascaded slices; the last slice drives the write-back
// outputs. The block also produces the write-back result mux and the
// forwarding match flags toward the execute stage, and counts retired
// instructions.
//
// Parameters
//   WIDTH  data-path width
//   DEPTH  number of cascaded slices, legal range 1..4
//   REGW   register-index width
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   StallW                    hold every slice and the retire counter
//   FlushW                    load a bubble into slice 0
//   ValidM, RegWriteM,
//   MemtoRegM, ReadDataM,
//   ALUOutM, WriteRegM        memory-stage bundle entering slice 0
//   RsE, RtE                  execute-stage source indices
//   ValidW, RegWriteW,
//   MemtoRegW, ReadDataW,
//   ALUOutW, WriteRegW        final-slice bundle
//   ResultW                   selected write-back value
//   FwdRsW, FwdRtW            write-back forwarding matches for RsE / RtE
//   RetireCount               retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module wb_pipe_stage #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1,
   parameter int REGW  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             StallW,
   input  logic             FlushW,
   input  logic             ValidM,
   input  logic             RegWriteM,
   input  logic             MemtoRegM,
   input  logic [WIDTH-1:0] ReadDataM,
   input  logic [WIDTH-1:0] ALUOutM,
   input  logic [REGW-1:0]  WriteRegM,
   input  logic [REGW-1:0]  RsE,
   input  logic [REGW-1:0]  RtE,
   output logic             ValidW,
   output logic             RegWriteW,
   output logic             MemtoRegW,
   output logic [WIDTH-1:0] ReadDataW,
   output logic [WIDTH-1:0] ALUOutW,
   output logic [WIDTH-1:0] ResultW,
   output logic [REGW-1:0]  WriteRegW,
   output logic             FwdRsW,
   output logic             FwdRtW,
   output logic [31:0]      RetireCount
);

   typedef struct packed {
      logic             valid;
      logic             reg_write;
      logic             mem_to_reg;
      logic [WIDTH-1:0] read_data;
      logic [WIDTH-1:0] alu_out;
      logic [REGW-1:0]  write_reg;
   } slice_t;

   slice_t      slice_q [DEPTH];
   slice_t      slice_d [DEPTH];
   slice_t      last_slice;
   logic [31:0] retire_q;
   logic [31:0] retire_d;
   logic        reg_write_w;

   assign last_slice = slice_q[DEPTH-1];

   // Next-state: hold by default, shift when not stalled. Flush only touches
   // slice 0 and wins over the stall, so a stalled flush bubbles slice 0 while
   // the downstream slices keep their contents.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         slice_d[k] = slice_q[k];
      end
      retire_d = retire_q;

      if (!StallW) begin
         for (int k = 1; k < DEPTH; k++) begin
            slice_d[k] = slice_q[k-1];
         end
         slice_d[0].valid      = ValidM;
         slice_d[0].reg_write  = RegWriteM;
         slice_d[0].mem_to_reg = MemtoRegM;
         slice_d[0].read_data  = ReadDataM;
         slice_d[0].alu_out    = ALUOutM;
         slice_d[0].write_reg  = WriteRegM;

         // An instruction retires on the edge that moves it out of the
         // final slice.
         if (last_slice.valid) begin
            retire_d = retire_q + 32'd1;
         end
      end

      if (FlushW) begin
         slice_d[0] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            slice_q[k] <= '0;
         end
         retire_q <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            slice_q[k] <= slice_d[k];
         end
         retire_q <= retire_d;
      end
   end

   // Register 0 is hard-wired, and bubbles must never write, so the stored
   // write enable is qualified by both.
   assign reg_write_w = last_slice.reg_write & last_slice.valid &
                        (last_slice.write_reg != '0);

   assign ValidW      = last_slice.valid;
   assign RegWriteW   = reg_write_w;
   assign MemtoRegW   = last_slice.mem_to_reg;
   assign ReadDataW   = last_slice.read_data;
   assign ALUOutW     = last_slice.alu_out;
   assign WriteRegW   = last_slice.write_reg;
   assign RetireCount = retire_q;

   always_comb begin
      ResultW = last_slice.alu_out;
      if (last_slice.mem_to_reg) begin
         ResultW = last_slice.read_data;
      end
   end

   assign FwdRsW = reg_write_w & (last_slice.write_reg == RsE);
   assign FwdRtW = reg_write_w & (last_slice.write_reg == RtE);

endmodule

// File: tb/tb_wb_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_pipe_stage
//
// Three instances (DEPTH 1, 2, 3) share one input stimulus; each is checked
// against hand-computed expectations at the falling edge after each rising
// edge.
// -----------------------------------------------------------------------------
module tb_wb_pipe_stage;

   logic        clk;
   logic        rst;
   logic        StallW;
   logic        FlushW;
   logic        ValidM;
   logic        RegWriteM;
   logic        MemtoRegM;
   logic [31:0] ReadDataM;
   logic [31:0] ALUOutM;
   logic [4:0]  WriteRegM;
   logic [4:0]  RsE;
   logic [4:0]  RtE;

   logic        valid_w      [1:3];
   logic        reg_write_w  [1:3];
   logic        mem_to_reg_w [1:3];
   logic [31:0] read_data_w  [1:3];
   logic [31:0] alu_out_w    [1:3];
   logic [31:0] result_w     [1:3];
   logic [4:0]  write_reg_w  [1:3];
   logic        fwd_rs_w     [1:3];
   logic        fwd_rt_w     [1:3];
   logic [31:0] retire_cnt   [1:3];

   int n_total = 0;
   int n_pass  = 0;

   wb_pipe_stage #(.WIDTH(32), .DEPTH(1), .REGW(5)) u_d1 (
      .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW),
      .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
      .ReadDataM(ReadDataM), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM),
      .RsE(RsE), .RtE(RtE),
      .ValidW(valid_w[1]), .RegWriteW(reg_write_w[1]), .MemtoRegW(mem_to_reg_w[1]),
      .ReadDataW(read_data_w[1]), .ALUOutW(alu_out_w[1]), .ResultW(result_w[1]),
      .WriteRegW(write_reg_w[1]), .FwdRsW(fwd_rs_w[1]), .FwdRtW(fwd_rt_w[1]),
      .RetireCount(retire_cnt[1])
   );

   wb_pipe_stage #(.WIDTH(32), .DEPTH(2), .REGW(5)) u_d2 (
      .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW),
      .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
      .ReadDataM(ReadDataM), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM),
      .RsE(RsE), .RtE(RtE),
      .ValidW(valid_w[2]), .RegWriteW(reg_write_w[2]), .MemtoRegW(mem_to_reg_w[2]),
      .ReadDataW(read_data_w[2]), .ALUOutW(alu_out_w[2]), .ResultW(result_w[2]),
      .WriteRegW(write_reg_w[2]), .FwdRsW(fwd_rs_w[2]), .FwdRtW(fwd_rt_w[2]),
      .RetireCount(retire_cnt[2])
   );

   wb_pipe_stage #(.WIDTH(32), .DEPTH(3), .REGW(5)) u_d3 (
      .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW),
      .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
      .ReadDataM(ReadDataM), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM),
      .RsE(RsE), .RtE(RtE),
      .ValidW(valid_w[3]), .RegWriteW(reg_write_w[3]), .MemtoRegW(mem_to_reg_w[3]),
      .ReadDataW(read_data_w[3]), .ALUOutW(alu_out_w[3]), .ResultW(result_w[3]),
      .WriteRegW(write_reg_w[3]), .FwdRsW(fwd_rs_w[3]), .FwdRtW(fwd_rt_w[3]),
      .RetireCount(retire_cnt[3])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // One rising edge passes; returns at the following falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic rw, input logic mtr,
                        input logic [31:0] rd, input logic [31:0] alu,
                        input logic [4:0] wr);
      ValidM    = v;
      RegWriteM = rw;
      MemtoRegM = mtr;
      ReadDataM = rd;
      ALUOutM   = alu;
      WriteRegM = wr;
   endtask

   task automatic bubble();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
   endtask

   initial begin
      rst    = 1'b1;
      StallW = 1'b0;
      FlushW = 1'b0;
      RsE    = 5'd0;
      RtE    = 5'd0;
      bubble();

      // ---------------- reset state ----------------
      tick();
      tick();
      chk("rst d1 ValidW",      {31'b0, valid_w[1]},     32'd0);
      chk("rst d1 RegWriteW",   {31'b0, reg_write_w[1]}, 32'd0);
      chk("rst d1 ResultW",     result_w[1],             32'd0);
      chk("rst d1 FwdRsW",      {31'b0, fwd_rs_w[1]},    32'd0);
      chk("rst d1 FwdRtW",      {31'b0, fwd_rt_w[1]},    32'd0);
      chk("rst d3 RetireCount", retire_cnt[3],           32'd0);
      chk("rst d3 WriteRegW",   {27'b0, write_reg_w[3]}, 32'd0);

      // ---------------- txn A: load result, latency per depth ----------------
      rst = 1'b0;
      RsE = 5'd8;
      RtE = 5'd3;
      drive(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0000_1234, 5'd8);
      tick();
      bubble();
      chk("A1 d1 ValidW",      {31'b0, valid_w[1]},     32'd1);
      chk("A1 d1 ResultW",     result_w[1],             32'hDEADBEEF);
      chk("A1 d1 RegWriteW",   {31'b0, reg_write_w[1]}, 32'd1);
      chk("A1 d1 FwdRsW",      {31'b0, fwd_rs_w[1]},    32'd1);
      chk("A1 d1 FwdRtW",      {31'b0, fwd_rt_w[1]},    32'd0);
      chk("A1 d1 RetireCount", retire_cnt[1],           32'd0);
      chk("A1 d2 ValidW",      {31'b0, valid_w[2]},     32'd0);
      chk("A1 d3 ValidW",      {31'b0, valid_w[3]},     32'd0);
      tick();
      chk("A2 d1 RetireCount", retire_cnt[1],           32'd1);
      chk("A2 d1 ValidW",      {31'b0, valid_w[1]},     32'd0);
      chk("A2 d2 ValidW",      {31'b0, valid_w[2]},     32'd1);
      chk("A2 d2 ResultW",     result_w[2],             32'hDEADBEEF);
      chk("A2 d3 ValidW",      {31'b0, valid_w[3]},     32'd0);
      tick();
      chk("A3 d3 ValidW",      {31'b0, valid_w[3]},     32'd1);
      chk("A3 d3 RetireCount", retire_cnt[3],           32'd0);
      chk("A3 d2 RetireCount", retire_cnt[2],           32'd1);
      tick();
      chk("A4 d3 RetireCount", retire_cnt[3],           32'd1);
      chk("A4 d1 RetireCount", retire_cnt[1],           32'd1);

      // ---------------- txn B: ALU result, DEPTH=3 exact latency ----------------
      RsE = 5'd9;
      RtE = 5'd3;
      drive(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0000_1234, 5'd9);
      tick();
      bubble();
      chk("B1 d1 ResultW",     result_w[1],             32'h0000_1234);
      chk("B1 d1 FwdRsW",      {31'b0, fwd_rs_w[1]},    32'd1);
      chk("B1 d1 FwdRtW",      {31'b0, fwd_rt_w[1]},    32'd0);
      chk("B1 d3 ValidW",      {31'b0, valid_w[3]},     32'd0);
      tick();
      chk("B2 d3 ValidW",      {31'b0, valid_w[3]},     32'd0);
      chk("B2 d1 RetireCount", retire_cnt[1],           32'd2);
      tick();
      chk("B3 d3 ValidW",      {31'b0, valid_w[3]},     32'd1);
      chk("B3 d3 ResultW",     result_w[3],             32'h0000_1234);
      chk("B3 d3 RegWriteW",   {31'b0, reg_write_w[3]}, 32'd1);
      chk("B3 d3 FwdRsW",      {31'b0, fwd_rs_w[3]},    32'd1);
      chk("B3 d3 FwdRtW",      {31'b0, fwd_rt_w[3]},    32'd0);
      tick();
      chk("B4 d3 RetireCount", retire_cnt[3],           32'd2);

      // ---------------- txn C: write to r0 is suppressed ----------------
      RsE = 5'd0;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0005, 5'd0);
      tick();
      bubble();
      chk("C1 d1 ValidW",      {31'b0, valid_w[1]},     32'd1);
      chk("C1 d1 RegWriteW",   {31'b0, reg_write_w[1]}, 32'd0);
      chk("C1 d1 FwdRsW",      {31'b0, fwd_rs_w[1]},    32'd0);
      chk("C1 d1 ResultW",     result_w[1],             32'd5);
      tick();
      chk("C2 d1 RetireCount", retire_cnt[1],           32'd3);

      // ---------------- txn D: invalid input is a bubble ----------------
      RsE = 5'd5;
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0077, 5'd5);
      tick();
      bubble();
      chk("D1 d1 ValidW",      {31'b0, valid_w[1]},     32'd0);
      chk("D1 d1 RegWriteW",   {31'b0, reg_write_w[1]}, 32'd0);
      chk("D1 d1 FwdRsW",      {31'b0, fwd_rs_w[1]},    32'd0);
      chk("D1 d1 WriteRegW",   {27'b0, write_reg_w[1]}, 32'd5);
      tick();
      chk("D2 d1 RetireCount", retire_cnt[1],           32'd3);

      // ---------------- stall / flush on DEPTH=2 ----------------
      rst = 1'b1;
      tick();
      rst = 1'b0;
      RsE = 5'd0;
      RtE = 5'd0;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0011, 5'd1);
      tick();
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0022, 5'd2);
      tick();
      chk("S0 d2 ResultW",     result_w[2],             32'h0000_0011);
      chk("S0 d2 RetireCount", retire_cnt[2],           32'd0);
      StallW = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0033, 5'd3);
      tick();
      tick();
      chk("S2 d2 ResultW",     result_w[2],             32'h0000_0011);
      chk("S2 d2 RetireCount", retire_cnt[2],           32'd0);
      tick();
      tick();
      chk("S4 d2 ValidW",      {31'b0, valid_w[2]},     32'd1);
      chk("S4 d2 ResultW",     result_w[2],             32'h0000_0011);
      chk("S4 d2 WriteRegW",   {27'b0, write_reg_w[2]}, 32'd1);
      chk("S4 d2 RetireCount", retire_cnt[2],           32'd0);
      chk("S4 d1 RetireCount", retire_cnt[1],           32'd1);
      FlushW = 1'b1;
      tick();
      chk("SF d2 ResultW",     result_w[2],             32'h0000_0011);
      chk("SF d2 RetireCount", retire_cnt[2],           32'd0);
      StallW = 1'b0;
      FlushW = 1'b0;
      bubble();
      tick();
      chk("SR d2 ValidW",      {31'b0, valid_w[2]},     32'd0);
      chk("SR d2 ALUOutW",     alu_out_w[2],            32'd0);
      chk("SR d2 RetireCount", retire_cnt[2],           32'd1);
      tick();
      chk("SR2 d2 RetireCount", retire_cnt[2],          32'd1);
      FlushW = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0044, 5'd4);
      tick();
      FlushW = 1'b0;
      bubble();
      chk("FL d1 ValidW",      {31'b0, valid_w[1]},     32'd0);
      chk("FL d1 ALUOutW",     alu_out_w[1],            32'd0);

      // ---------------- retire counter wrap on DEPTH=1 ----------------
      rst = 1'b1;
      tick();
      rst = 1'b0;
      StallW = 1'b1;
      force u_d1.retire_q = 32'hFFFF_FFFF;
      tick();
      release u_d1.retire_q;
      StallW = 1'b0;
      chk("W0 d1 RetireCount", retire_cnt[1],           32'hFFFF_FFFF);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd6);
      tick();
      bubble();
      chk("W1 d1 RetireCount", retire_cnt[1],           32'hFFFF_FFFF);
      tick();
      chk("W2 d1 RetireCount", retire_cnt[1],           32'd0);

      // ---------------- reset with instructions in flight, DEPTH=3 ----------------
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 32'hA1, 32'h0, 5'd11);
      tick();
      drive(1'b1, 1'b1, 1'b1, 32'hA2, 32'h0, 5'd12);
      tick();
      drive(1'b1, 1'b1, 1'b1, 32'hA3, 32'h0, 5'd13);
      tick();
      drive(1'b1, 1'b1, 1'b1, 32'hA4, 32'h0, 5'd14);
      tick();
      chk("R0 d3 ResultW",     result_w[3],             32'h0000_00A2);
      chk("R0 d3 RetireCount", retire_cnt[3],           32'd1);
      rst    = 1'b1;
      StallW = 1'b1;
      FlushW = 1'b1;
      bubble();
      tick();
      rst    = 1'b0;
      StallW = 1'b0;
      FlushW = 1'b0;
      chk("R1 d3 ValidW",      {31'b0, valid_w[3]},     32'd0);
      chk("R1 d3 ResultW",     result_w[3],             32'd0);
      chk("R1 d3 WriteRegW",   {27'b0, write_reg_w[3]}, 32'd0);
      chk("R1 d3 MemtoRegW",   {31'b0, mem_to_reg_w[3]}, 32'd0);
      chk("R1 d3 ReadDataW",   read_data_w[3],          32'd0);
      chk("R1 d3 RetireCount", retire_cnt[3],           32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("R2 d3 ValidW",   {31'b0, valid_w[3]},     32'd0);
         chk("R2 d3 ReadDataW", read_data_w[3],         32'd0);
      end
      chk("R3 d3 RetireCount", retire_cnt[3],           32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
